// File: rtl/str_stream_tokenizer.sv
// Streaming tokenizer: splits a byte stream on a programmable multi-byte delimiter,
// with quote protection, optional whitespace stripping and truncation flagging.
module str_stream_tokenizer #(
  parameter int MaxTokLen   = 32,
  parameter int MaxDelimLen = 4,
  parameter int CntW        = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [MaxDelimLen*8-1:0]         cfg_delim_i,
  input  logic [$clog2(MaxDelimLen+1)-1:0] cfg_delim_len_i,
  input  logic                             cfg_strip_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [7:0]                       in_data_i,
  input  logic                             in_last_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [7:0]                       out_data_o,
  output logic                             out_first_o,
  output logic                             out_last_o,
  output logic                             out_trunc_o,
  output logic                             out_eos_o,
  output logic [CntW-1:0]                  tok_count_o
);
  localparam int DLW = $clog2(MaxDelimLen + 1);
  localparam int LW  = $clog2(MaxTokLen + 1);
  localparam int IW  = $clog2(MaxTokLen);
  localparam int DIW = (MaxDelimLen > 1) ? $clog2(MaxDelimLen) : 1;
  localparam int HD  = (MaxDelimLen > 1) ? MaxDelimLen - 1 : 1;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  logic [0:0]                  state_q;
  logic [7:0]                  buf_q [MaxTokLen];
  logic [LW-1:0]               len_q, tok_len_q, rd_q;
  logic [MaxTokLen-1:0]        nws_q;
  logic                        trunc_q, eos_q, quote_q, active_q, strip_q;
  logic [HD-1:0][7:0]          hist_q;
  logic [MaxDelimLen-1:0][7:0] delim_q, delim_eff;
  logic [DLW-1:0]              dlen_q, dlen_eff;
  logic [CntW-1:0]             cnt_q;

  logic                        strip_eff, accept, ws, quote_nx, match;
  logic                        drop_lead, full, wr, ovf, tok_end;
  logic [MaxDelimLen-1:0][7:0] hist_sh;
  logic [LW-1:0]               len_nx, elen, dm1;
  logic [MaxTokLen-1:0]        nws_nx;

  // The first byte of a string sees the live config; later bytes the latched copy.
  assign delim_eff = active_q ? delim_q : cfg_delim_i;
  assign dlen_eff  = active_q ? dlen_q  : cfg_delim_len_i;
  assign strip_eff = active_q ? strip_q : cfg_strip_i;

  assign accept    = (state_q == COLLECT) && in_valid_i;
  assign ws        = strip_eff && (in_data_i == 8'h20 || in_data_i == 8'h09 || in_data_i == 8'h0A);
  assign quote_nx  = quote_q ^ (in_data_i == 8'h22);
  assign drop_lead = ws && (len_q == '0);
  assign full      = (len_q == LW'(MaxTokLen));
  assign wr        = accept && !match && !drop_lead && !full;
  assign ovf       = accept && !match && !drop_lead && full;
  assign tok_end   = accept && (match || in_last_i);
  assign dm1       = LW'(dlen_eff) - LW'(1);

  // hist_sh[0] is the incoming byte; older bytes follow at higher indices.
  always_comb begin
    hist_sh[0] = in_data_i;
    for (int i = 1; i < MaxDelimLen; i++) hist_sh[i] = hist_q[i-1];
  end

  always_comb begin
    logic [DIW-1:0] k;
    k     = '0;
    match = accept && !quote_nx && (dlen_eff != '0);
    for (int i = 0; i < MaxDelimLen; i++) begin
      k = DIW'(int'(dlen_eff) - 1 - i);
      if (i < int'(dlen_eff) && hist_sh[k] != delim_eff[i]) match = 1'b0;
    end
  end

  // nws tracks which stored positions hold non-whitespace; the emitted length
  // is the highest such position below the (possibly shortened) buffer length.
  always_comb begin
    len_nx = len_q;
    nws_nx = nws_q;
    if (match) begin
      len_nx = (len_q > dm1) ? len_q - dm1 : '0;
    end else if (wr) begin
      len_nx = len_q + LW'(1);
      nws_nx[len_q[IW-1:0]] = !ws;
    end
    elen = '0;
    for (int i = 0; i < MaxTokLen; i++)
      if (nws_nx[i] && i < int'(len_nx)) elen = LW'(i + 1);
  end

  always_ff @(posedge clk_i) begin
    if (wr) buf_q[len_q[IW-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= COLLECT;
      len_q     <= '0;
      tok_len_q <= '0;
      rd_q      <= '0;
      nws_q     <= '0;
      trunc_q   <= 1'b0;
      eos_q     <= 1'b0;
      quote_q   <= 1'b0;
      active_q  <= 1'b0;
      strip_q   <= 1'b0;
      hist_q    <= '0;
      delim_q   <= '0;
      dlen_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        quote_q <= in_last_i ? 1'b0 : quote_nx;
        hist_q  <= (match || in_last_i) ? '0 : hist_sh[HD-1:0];
        if (in_last_i) begin
          active_q <= 1'b0;
        end else if (!active_q) begin
          active_q <= 1'b1;
          delim_q  <= cfg_delim_i;
          dlen_q   <= cfg_delim_len_i;
          strip_q  <= cfg_strip_i;
        end
      end
      case (state_q)
        COLLECT: begin
          if (tok_end && elen != '0) begin
            state_q   <= EMIT;
            tok_len_q <= elen;
            rd_q      <= '0;
            eos_q     <= !match;
            trunc_q   <= trunc_q | ovf;
            len_q     <= len_nx;
            nws_q     <= nws_nx;
          end else if (tok_end) begin
            len_q   <= '0;
            nws_q   <= '0;
            trunc_q <= 1'b0;
          end else if (accept) begin
            len_q   <= len_nx;
            nws_q   <= nws_nx;
            trunc_q <= trunc_q | ovf;
          end
        end
        default: begin
          if (out_ready_i) begin
            if (out_last_o) begin
              cnt_q   <= cnt_q + CntW'(1);
              len_q   <= '0;
              nws_q   <= '0;
              trunc_q <= 1'b0;
              state_q <= COLLECT;
            end else begin
              rd_q <= rd_q + LW'(1);
            end
          end
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == COLLECT);
  assign out_valid_o = (state_q == EMIT);
  assign out_data_o  = out_valid_o ? buf_q[rd_q[IW-1:0]] : 8'h00;
  assign out_first_o = out_valid_o && (rd_q == '0);
  assign out_last_o  = out_valid_o && (rd_q == tok_len_q - LW'(1));
  assign out_trunc_o = out_last_o && trunc_q;
  assign out_eos_o   = out_last_o && eos_q;
  assign tok_count_o = cnt_q;
endmodule
